voice_scheduler: RTL
====================

VOICE_SCHEDULER -- requirements
Module: voice_scheduler

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 3, number of time-multiplexed voices.
REQ-002 SHALL have parameter STEP_W, default 20, phase-increment and phase-accumulator width.
REQ-003 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port generate_next_sample, input, 1, one-cycle request to compute one output sample pair.
REQ-006 SHALL have port stereo_on, input, 1, 1 enables per-voice panning; 0 routes every voice to both channels.
REQ-007 SHALL have port voice_active, input, NUM_VOICES, per-voice enable.
REQ-008 SHALL have port step_size, input, NUM_VOICES*STEP_W, per-voice phase increment; voice v at bits [v*STEP_W +: STEP_W].
REQ-009 SHALL have port stereo_side, input, 2*NUM_VOICES, per-voice pan code.
REQ-010 SHALL have port rom_addr, output, 10, address to the shared sine ROM.
REQ-011 SHALL have port rom_data, input, 16, signed ROM word, valid exactly 1 cycle after rom_addr.
REQ-012 SHALL have port sample_left, output, 16, signed left sample; held until the next update.
REQ-013 SHALL have port sample_right, output, 16, signed right sample; held until the next update.
REQ-014 SHALL have port sample_valid, output, 1, one-cycle pulse when the sample outputs update.
REQ-015 SHALL have port busy, output, 1, high while not IDLE.
REQ-016 SHALL have port overrun, output, 1, sticky flag for a request received while busy.

Function
REQ-017 SHALL implement the states IDLE, ADDR, DATA and OUT, with a voice index v.
REQ-018 IDLE SHALL move to ADDR with v=0 on generate_next_sample; otherwise it SHALL stay in IDLE.
REQ-019 ADDR SHALL drive rom_addr = phase[v][STEP_W-1 -: 10], then phase[v] += step_size[v] modulo 2^STEP_W, then move to DATA.
REQ-020 DATA SHALL add sign-extended rom_data into 18-bit signed accumulators acc_l/acc_r per pan code, then move to ADDR with v+1, or to OUT after v=NUM_VOICES-1.
REQ-021 Pan codes: 00 adds to both channels, 01 to left only, 10 to right only, 11 to both; when stereo_on=0 every voice SHALL add to both.
REQ-022 voice_active[v] SHALL be sampled in ADDR; an inactive voice SHALL contribute 0, its phase SHALL be forced to 0, and its cycle count SHALL be unchanged.
REQ-023 step_size and stereo_side SHALL be sampled in the ADDR and DATA cycles of each voice.
REQ-024 OUT SHALL saturate acc_l/acc_r to the range [-32768, 32767], register them into sample_left/right, pulse sample_valid, clear the accumulators and return to IDLE.
REQ-025 Latency: sample_valid SHALL be high exactly 2*NUM_VOICES+1 cycles after the cycle in which generate_next_sample was high (7 cycles for the default).
REQ-026 generate_next_sample while busy=1 (including in OUT) SHALL be dropped and SHALL set overrun; overrun SHALL clear only on reset.
REQ-027 rom_addr SHALL hold its last value outside ADDR.

Reset
REQ-028 reset_n low SHALL immediately clear the state to IDLE, v, all phases, the accumulators, sample_left, sample_right, sample_valid, busy, overrun and rom_addr to 0.
REQ-029 A reset mid-sequence SHALL abort without emitting sample_valid; the next request after release SHALL behave as the first.

Structure
REQ-030 Pan-code constants, the state encoding and ROM_ADDR_W=10 SHALL live in the shared package audio_pkg.
REQ-031 Saturation SHALL be the single sub-module sat18to16.
REQ-032 The ROM SHALL be external to this block.

Verification
REQ-033 Reset, then one request with all voices inactive -> sample_valid at +7 cycles, outputs 0/0, rom_addr sequence 0,0,0.
REQ-034 Voice 0 active, step 0x00400, pan 01, ROM returning addr*16 -> over successive requests rom_addr 0,1,2, left 0,16,32, right 0.
REQ-035 Three voices active, pan 00, rom_data 0x7000 each -> left=right=32767 (saturated); with 0x9000 each -> -32768.
REQ-036 stereo_on=0, voice 1 pan 10, rom_data 100 -> left=right=100; stereo_on=1 -> left 0, right 100.
REQ-037 Second request 3 cycles after the first -> one sample_valid only, overrun=1 and held.
REQ-038 reset_n low during DATA of voice 1 -> no sample_valid, all outputs 0 immediately; the next request -> valid at +7 cycles with phases restarting from 0.

Source files
------------

// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : audio_pkg
// Description : Shared constants and types for the voice scheduler:
//               pan codes, scheduler state encoding and the sine ROM
//               address width.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package audio_pkg;

    localparam int ROM_ADDR_W = 10;

    // Pan codes, two bits per voice
    localparam logic [1:0] PAN_CENTER = 2'b00;   // both channels
    localparam logic [1:0] PAN_LEFT   = 2'b01;   // left only
    localparam logic [1:0] PAN_RIGHT  = 2'b10;   // right only
    localparam logic [1:0] PAN_BOTH   = 2'b11;   // both channels

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_OUT  = 2'd3
    } sched_state_t;

endpackage : audio_pkg
`default_nettype wire

// File: rtl/sat18to16.sv
`default_nettype none
// ============================================================================
// Module      : sat18to16
// Description : Clamps an 18-bit signed value to the 16-bit signed range
//               [-32768, 32767].
// Ports       : din  - 18-bit signed input
//               dout - 16-bit signed saturated output
// Revision    : 1.0 - initial release
// ============================================================================
module sat18to16 (
    input  logic signed [17:0] din,
    output logic signed [15:0] dout
);

    // The value fits in 16 bits when the top three bits are all equal.
    always_comb begin
        dout = din[15:0];
        if (din[17] && (din[16:15] != 2'b11)) begin
            dout = 16'sh8000;
        end else if (!din[17] && (din[16:15] != 2'b00)) begin
            dout = 16'sh7FFF;
        end
    end

endmodule : sat18to16
`default_nettype wire

// File: rtl/voice_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : voice_scheduler
// Description : Time-multiplexes NUM_VOICES phase-accumulator voices onto a
//               single external sine ROM, mixing them into a saturated
//               stereo sample pair per request.
// Ports       : clk, reset_n            - clock, async active-low reset
//               generate_next_sample    - one-cycle sample request
//               stereo_on               - enable per-voice panning
//               voice_active            - per-voice enable
//               step_size               - per-voice phase increment
//               stereo_side             - per-voice 2-bit pan code
//               rom_addr / rom_data     - sine ROM port (1-cycle latency)
//               sample_left/right       - saturated output samples
//               sample_valid            - one-cycle update pulse
//               busy, overrun           - status (overrun is sticky)
// Revision    : 1.0 - initial release
// ============================================================================
module voice_scheduler
    import audio_pkg::*;
#(
    parameter int NUM_VOICES = 3,
    parameter int STEP_W     = 20
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           generate_next_sample,
    input  logic                           stereo_on,
    input  logic [NUM_VOICES-1:0]          voice_active,
    input  logic [NUM_VOICES*STEP_W-1:0]   step_size,
    input  logic [2*NUM_VOICES-1:0]        stereo_side,
    output logic [ROM_ADDR_W-1:0]          rom_addr,
    input  logic signed [15:0]             rom_data,
    output logic signed [15:0]             sample_left,
    output logic signed [15:0]             sample_right,
    output logic                           sample_valid,
    output logic                           busy,
    output logic                           overrun
);

    localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [VW-1:0] LAST_V = VW'(NUM_VOICES - 1);

    sched_state_t            state, state_nxt;
    logic [VW-1:0]           v;
    logic [STEP_W-1:0]       phase [NUM_VOICES];
    logic                    active_q;
    logic signed [17:0]      acc_l, acc_r;
    logic [ROM_ADDR_W-1:0]   rom_addr_q;

    logic [STEP_W-1:0]       cur_step;
    logic [1:0]              cur_pan;
    logic signed [17:0]      rom_ext;
    logic                    add_l, add_r;
    logic signed [17:0]      sum_l, sum_r;
    logic signed [15:0]      sat_l, sat_r;
    logic                    last_voice;

    assign cur_step   = step_size[v*STEP_W +: STEP_W];
    assign cur_pan    = stereo_side[v*2 +: 2];
    assign rom_ext    = {{2{rom_data[15]}}, rom_data};
    assign last_voice = (v == LAST_V);
    assign busy       = (state != ST_IDLE);

    // The ROM registers its address at the end of ADDR, so the address must
    // be visible combinationally during ADDR and held afterwards.
    assign rom_addr = (state == ST_ADDR) ? phase[v][STEP_W-1 -: ROM_ADDR_W]
                                         : rom_addr_q;

    always_comb begin
        add_l = active_q && (!stereo_on || (cur_pan != PAN_RIGHT));
        add_r = active_q && (!stereo_on || (cur_pan != PAN_LEFT));
        sum_l = acc_l + (add_l ? rom_ext : 18'sd0);
        sum_r = acc_r + (add_r ? rom_ext : 18'sd0);
    end

    sat18to16 u_sat_l (.din(sum_l), .dout(sat_l));
    sat18to16 u_sat_r (.din(sum_r), .dout(sat_r));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (generate_next_sample) state_nxt = ST_ADDR;
            ST_ADDR: state_nxt = ST_DATA;
            ST_DATA: state_nxt = last_voice ? ST_OUT : ST_ADDR;
            ST_OUT:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The saturated result is registered as the last voice is mixed, so the
    // OUT cycle is the one in which the new sample pair and sample_valid are
    // presented; OUT then clears the accumulators.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v            <= '0;
            active_q     <= 1'b0;
            acc_l        <= '0;
            acc_r        <= '0;
            rom_addr_q   <= '0;
            sample_left  <= '0;
            sample_right <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase[i] <= '0;
            end
        end else begin
            sample_valid <= 1'b0;
            if (generate_next_sample && busy) begin
                overrun <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    v <= '0;
                end
                ST_ADDR: begin
                    rom_addr_q <= phase[v][STEP_W-1 -: ROM_ADDR_W];
                    active_q   <= voice_active[v];
                    phase[v]   <= voice_active[v] ? (phase[v] + cur_step) : '0;
                end
                ST_DATA: begin
                    acc_l <= sum_l;
                    acc_r <= sum_r;
                    if (last_voice) begin
                        sample_left  <= sat_l;
                        sample_right <= sat_r;
                        sample_valid <= 1'b1;
                        v            <= '0;
                    end else begin
                        v <= v + VW'(1);
                    end
                end
                ST_OUT: begin
                    acc_l <= '0;
                    acc_r <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule : voice_scheduler
`default_nettype wire
